// File: rtl/lstm_fc_pkg.sv
// Shared definitions for the LSTM core and its FC output layer.
// State encoding for the FC sequencer plus layer dimensions.
package lstm_fc_pkg;

  typedef logic [2:0] fc_state_t;

  localparam fc_state_t ST_IDLE  = 3'd0;
  localparam fc_state_t ST_MAC   = 3'd1;
  localparam fc_state_t ST_DRAIN = 3'd2;
  localparam fc_state_t ST_BIAS  = 3'd3;
  localparam fc_state_t ST_OUT   = 3'd4;
  localparam fc_state_t ST_DONE  = 3'd5;

  localparam int FC_IN_NUM  = 30;
  localparam int FC_OUT_NUM = 10;

endpackage

// File: rtl/fc_addr_gen.sv
// Input/output/weight counters for the FC layer walk.
// The weight address holds at its last legal value on the final MAC cycle.
module fc_addr_gen #(
  parameter int IN_NUM  = 30,
  parameter int OUT_NUM = 10,
  parameter int WA_W    = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_mac_step,
  input  logic            i_out_step,
  output logic [7:0]      o_in_cnt,
  output logic [7:0]      o_out_cnt,
  output logic [WA_W-1:0] o_w_addr,
  output logic            o_in_last,
  output logic            o_out_last
);

  logic [7:0]      r_in_cnt;
  logic [7:0]      r_out_cnt;
  logic [WA_W-1:0] r_w_addr;

  assign o_in_last  = (r_in_cnt == 8'(IN_NUM - 1));
  assign o_out_last = (r_out_cnt == 8'(OUT_NUM - 1));
  assign o_in_cnt   = r_in_cnt;
  assign o_out_cnt  = r_out_cnt;
  assign o_w_addr   = r_w_addr;

  // Counter update: clear wins, MAC steps inputs/weights, OUT steps neurons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_w_addr  <= '0;
    end else if (i_clr) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_w_addr  <= '0;
    end else begin
      if (i_mac_step) begin
        r_in_cnt <= o_in_last ? '0 : r_in_cnt + 8'd1;
        if (!(o_in_last && o_out_last))
          r_w_addr <= r_w_addr + 1'b1;
      end
      if (i_out_step)
        r_out_cnt <= r_out_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// FC layer sequencer: MAC walk, pipeline drain, bias add, result handshake.
// Outputs are decoded from registered state and counters.
module fc_layer_ctrl
  import lstm_fc_pkg::*;
#(
  parameter int IN_NUM   = FC_IN_NUM,
  parameter int OUT_NUM  = FC_OUT_NUM,
  parameter int PIPE_LAT = 3,
  parameter int WA_W     = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            out_ready,
  output logic            busy,
  output logic [7:0]      h_rd_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [7:0]      b_addr,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            bias_add,
  output logic            out_valid,
  output logic [7:0]      out_idx,
  output logic            done
);

  fc_state_t       r_state;
  fc_state_t       w_next;
  logic [3:0]      r_drain;
  logic            w_drain_end;
  logic [7:0]      w_in_cnt;
  logic [7:0]      w_out_cnt;
  logic [WA_W-1:0] w_wa;
  logic            w_in_last;
  logic            w_out_last;
  logic            w_cnt_clr;
  logic            w_mac_step;
  logic            w_out_step;

  assign w_drain_end = (r_drain == 4'(PIPE_LAT - 1));
  assign w_cnt_clr   = abort || (r_state == ST_IDLE);
  assign w_mac_step  = (r_state == ST_MAC) && !abort;
  assign w_out_step  = (r_state == ST_OUT) && out_ready
                       && !w_out_last && !abort;

  fc_addr_gen #(
    .IN_NUM  (IN_NUM),
    .OUT_NUM (OUT_NUM),
    .WA_W    (WA_W)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_mac_step (w_mac_step),
    .i_out_step (w_out_step),
    .o_in_cnt   (w_in_cnt),
    .o_out_cnt  (w_out_cnt),
    .o_w_addr   (w_wa),
    .o_in_last  (w_in_last),
    .o_out_last (w_out_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Drain counter runs only while waiting out the MAC pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drain <= '0;
    else if (abort || r_state != ST_DRAIN)
      r_drain <= '0;
    else
      r_drain <= r_drain + 4'd1;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_MAC;
      ST_MAC:   if (w_in_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_next = ST_BIAS;
      ST_BIAS:  w_next = ST_OUT;
      ST_OUT:   if (out_ready)
                  w_next = w_out_last ? ST_DONE : ST_MAC;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  // Output decode
  always_comb begin
    busy      = 1'b0;
    h_rd_addr = '0;
    w_addr    = '0;
    b_addr    = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    bias_add  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    done      = 1'b0;
    if (r_state != ST_IDLE) begin
      busy   = 1'b1;
      w_addr = w_wa;
    end
    unique case (1'b1)
      (r_state == ST_MAC): begin
        mac_en    = 1'b1;
        mac_clr   = (w_in_cnt == 8'd0);
        h_rd_addr = w_in_cnt;
      end
      (r_state == ST_BIAS): begin
        bias_add = 1'b1;
        b_addr   = w_out_cnt;
      end
      (r_state == ST_OUT): begin
        out_valid = 1'b1;
        out_idx   = w_out_cnt;
      end
      (r_state == ST_DONE): done = 1'b1;
      default: ;
    endcase
  end

endmodule
